rgb_line_packetizer: RTL and testbench

- Sits directly downstream of the HDMI capture/downscale stage.
- Consumes its pixel write stream: enable, 24-bit frame pixel address, 8-bit R/G/B.
- Buffers one complete scaled line in a ping-pong line buffer, then emits that line as a byte-wide AXI-Stream packet (4-byte header + RGB payload) toward the Ethernet TX framer.
- Everything runs in the pixel clock domain.

---
 rtl/rgb_pkt_pkg.sv | 24 ++
 rtl/line_buf_dp.sv | 24 ++
 rtl/rgb_line_packetizer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_rgb_line_packetizer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkt_pkg.sv
// Shared types and constants for the RGB line packetizer.
// Header layout: MAGIC, frame id, line hi, line lo.
package rgb_pkt_pkg;

  localparam int         HDR_BYTES = 4;
  localparam logic [7:0] MAGIC_DEF = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PIX
  } state_t;

  typedef enum logic [1:0] {
    SEL_R,
    SEL_G,
    SEL_B
  } bsel_t;

  function automatic int pkt_len(input int h);
    return HDR_BYTES + 3 * h;
  endfunction

endpackage

// File: rtl/line_buf_dp.sv
// Ping-pong line storage: two banks of 24-bit pixels.
// One write port, one registered read port.
module line_buf_dp #(
  parameter int DEPTH = 960,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [23:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [23:0]   o_rdata
);

  logic [23:0] r_mem [DEPTH];

  // write on we; read data registered one clock after address
  always_ff @(posedge i_Clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/rgb_line_packetizer.sv
// Buffers scaled lines in two banks and emits each as a
// byte-wide stream packet: 4-byte header then R,G,B bytes.
module rgb_line_packetizer
  import rgb_pkt_pkg::*;
#(
  parameter int         H_PIXELS = 480,
  parameter int         LINE_W   = 16,
  parameter logic [7:0] MAGIC    = MAGIC_DEF
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_ena,
  input  logic [23:0] i_bramaddr24b,
  input  logic [7:0]  i_rgb_r,
  input  logic [7:0]  i_rgb_g,
  input  logic [7:0]  i_rgb_b,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_tlast,
  output logic [15:0] o_drop_cnt,
  output logic [7:0]  o_frame_id
);

  localparam int CW = $clog2(H_PIXELS);
  localparam int AW = $clog2(2 * H_PIXELS);
  localparam logic [CW-1:0] LAST_COL = CW'(H_PIXELS - 1);

  // write side state
  logic [CW-1:0]     r_wr_col;
  logic              r_wr_sel;
  logic [LINE_W-1:0] r_line_cnt;
  logic [7:0]        r_frame_id;
  logic              r_drop;
  logic [15:0]       r_drop_cnt;
  logic [1:0]        r_full;
  logic [LINE_W-1:0] r_line_tag [2];
  logic [7:0]        r_fid_tag  [2];

  // read side state
  state_t        r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_pcol;
  bsel_t         r_bsel;
  logic [23:0]   r_cur;
  logic [CW-1:0] r_rd_col;
  logic          r_rd_sel;
  logic [7:0]    r_tdata;
  logic          r_tvalid;
  logic          r_tlast;

  // next-state values from the read FSM
  state_t        w_state_n;
  logic [1:0]    w_idx_n;
  logic [CW-1:0] w_pcol_n;
  bsel_t         w_bsel_n;
  logic [23:0]   w_cur_n;
  logic [CW-1:0] w_rd_col_n;
  logic          w_rd_sel_n;
  logic [7:0]    w_tdata_n;
  logic          w_tvalid_n;
  logic          w_tlast_n;
  logic          w_full_clr;

  logic              w_first;
  logic [CW-1:0]     w_col;
  logic [LINE_W-1:0] w_line;
  logic [7:0]        w_fid;
  logic              w_col0;
  logic              w_eol;
  logic              w_acc;
  logic              w_we;
  logic              w_full_set;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [23:0]       w_rdata;
  logic [15:0]       w_ltag;
  logic [7:0]        w_hdr_nxt;
  logic              w_last_pix;
  logic [CW-1:0]     w_rd_col_inc;

  // address 0 restarts the frame before this pixel is placed
  assign w_first = (i_bramaddr24b == 24'd0);
  assign w_col   = w_first ? '0 : r_wr_col;
  assign w_line  = w_first ? '0 : r_line_cnt;
  assign w_fid   = w_first ? r_frame_id + 8'd1 : r_frame_id;
  assign w_col0  = (w_col == '0);
  assign w_eol   = (w_col == LAST_COL);
  assign w_acc   = w_col0 ? !r_full[r_wr_sel] : !r_drop;
  assign w_we    = i_ena && w_acc && !i_Rst;
  assign w_full_set = i_ena && w_acc && w_eol;

  assign w_waddr = r_wr_sel ? AW'(H_PIXELS) + AW'(w_col)
                            : AW'(w_col);
  assign w_raddr = r_rd_sel ? AW'(H_PIXELS) + AW'(r_rd_col)
                            : AW'(r_rd_col);

  line_buf_dp #(
    .DEPTH(2 * H_PIXELS),
    .AW   (AW)
  ) u_buf (
    .i_Clk  (i_Clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata({i_rgb_r, i_rgb_g, i_rgb_b}),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  // write side: column/line/frame tracking, accept or drop lines
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_wr_col      <= '0;
      r_wr_sel      <= 1'b0;
      r_line_cnt    <= '0;
      r_frame_id    <= '0;
      r_drop        <= 1'b0;
      r_drop_cnt    <= '0;
      r_line_tag[0] <= '0;
      r_line_tag[1] <= '0;
      r_fid_tag[0]  <= '0;
      r_fid_tag[1]  <= '0;
    end else if (i_ena) begin
      r_frame_id <= w_fid;
      if (w_col0) begin
        r_drop <= !w_acc;
        if (!w_acc && r_drop_cnt != 16'hFFFF)
          r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_eol) begin
        r_wr_col   <= '0;
        r_line_cnt <= w_line + LINE_W'(1);
        if (w_acc) begin
          r_line_tag[r_wr_sel] <= w_line;
          r_fid_tag[r_wr_sel]  <= w_fid;
          r_wr_sel             <= ~r_wr_sel;
        end
      end else begin
        r_wr_col   <= w_col + CW'(1);
        r_line_cnt <= w_line;
      end
    end
  end

  // bank occupancy: set by writer, cleared by reader
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_full <= 2'b00;
    end else begin
      if (w_full_set)
        r_full[r_wr_sel] <= 1'b1;
      if (w_full_clr)
        r_full[r_rd_sel] <= 1'b0;
    end
  end

  // header byte following the one currently presented
  always_comb begin
    w_ltag = 16'(r_line_tag[r_rd_sel]);
    unique case (r_idx)
      2'd0:    w_hdr_nxt = r_fid_tag[r_rd_sel];
      2'd1:    w_hdr_nxt = w_ltag[15:8];
      default: w_hdr_nxt = w_ltag[7:0];
    endcase
  end

  assign w_last_pix   = (r_pcol == LAST_COL);
  assign w_rd_col_inc = (r_rd_col == LAST_COL) ? r_rd_col
                                               : r_rd_col + CW'(1);

  // read FSM: next state and next registered stream outputs
  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_pcol_n   = r_pcol;
    w_bsel_n   = r_bsel;
    w_cur_n    = r_cur;
    w_rd_col_n = r_rd_col;
    w_rd_sel_n = r_rd_sel;
    w_tdata_n  = r_tdata;
    w_tvalid_n = r_tvalid;
    w_tlast_n  = r_tlast;
    w_full_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_full[r_rd_sel]) begin
          w_state_n  = HDR;
          w_idx_n    = 2'd0;
          w_tdata_n  = MAGIC;
          w_tvalid_n = 1'b1;
          w_tlast_n  = 1'b0;
        end
      end
      HDR: begin
        if (i_tready) begin
          if (r_idx == 2'd3) begin
            w_state_n  = PIX;
            w_cur_n    = w_rdata;
            w_tdata_n  = w_rdata[23:16];
            w_bsel_n   = SEL_R;
            w_pcol_n   = '0;
            w_rd_col_n = w_rd_col_inc;
          end else begin
            w_idx_n   = r_idx + 2'd1;
            w_tdata_n = w_hdr_nxt;
          end
        end
      end
      PIX: begin
        if (i_tready) begin
          unique case (r_bsel)
            SEL_R: begin
              w_tdata_n = r_cur[15:8];
              w_bsel_n  = SEL_G;
            end
            SEL_G: begin
              w_tdata_n = r_cur[7:0];
              w_tlast_n = w_last_pix;
              w_bsel_n  = SEL_B;
            end
            SEL_B: begin
              if (w_last_pix) begin
                w_state_n  = IDLE;
                w_tvalid_n = 1'b0;
                w_tlast_n  = 1'b0;
                w_tdata_n  = 8'd0;
                w_full_clr = 1'b1;
                w_rd_sel_n = ~r_rd_sel;
                w_rd_col_n = '0;
              end else begin
                w_cur_n    = w_rdata;
                w_tdata_n  = w_rdata[23:16];
                w_bsel_n   = SEL_R;
                w_pcol_n   = r_pcol + CW'(1);
                w_rd_col_n = w_rd_col_inc;
              end
            end
            default: w_bsel_n = SEL_R;
          endcase
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // read FSM state and stream output registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state  <= IDLE;
      r_idx    <= 2'd0;
      r_pcol   <= '0;
      r_bsel   <= SEL_R;
      r_cur    <= '0;
      r_rd_col <= '0;
      r_rd_sel <= 1'b0;
      r_tdata  <= 8'd0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_idx    <= w_idx_n;
      r_pcol   <= w_pcol_n;
      r_bsel   <= w_bsel_n;
      r_cur    <= w_cur_n;
      r_rd_col <= w_rd_col_n;
      r_rd_sel <= w_rd_sel_n;
      r_tdata  <= w_tdata_n;
      r_tvalid <= w_tvalid_n;
      r_tlast  <= w_tlast_n;
    end
  end

  assign o_tdata    = r_tdata;
  assign o_tvalid   = r_tvalid;
  assign o_tlast    = r_tlast;
  assign o_drop_cnt = r_drop_cnt;
  assign o_frame_id = r_frame_id;

endmodule

// File: tb/tb_rgb_line_packetizer.sv
// Random-stimulus bench for rgb_line_packetizer against a
// line-level queue model of the expected packet bytes.
module tb_rgb_line_packetizer;
  import rgb_pkt_pkg::*;

  localparam int H    = 480;
  localparam int PLEN = pkt_len(H);

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [23:0] addr;
  logic [7:0]  pr_i, pg_i, pb_i;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [15:0] drop_cnt;
  logic [7:0]  frame_id;

  always #5 clk = ~clk;

  rgb_line_packetizer #(
    .H_PIXELS(H),
    .LINE_W  (16),
    .MAGIC   (8'hA5)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_ena        (ena),
    .i_bramaddr24b(addr),
    .i_rgb_r      (pr_i),
    .i_rgb_g      (pg_i),
    .i_rgb_b      (pb_i),
    .o_tdata      (tdata),
    .o_tvalid     (tvalid),
    .i_tready     (tready),
    .o_tlast      (tlast),
    .o_drop_cnt   (drop_cnt),
    .o_frame_id   (frame_id)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: expected {tlast,byte} stream and line bookkeeping
  logic [8:0]  exp_q [$];
  logic [7:0]  m_pix [$];
  int          m_occ;
  logic [7:0]  m_fid;
  logic [15:0] m_line;
  int          m_col;
  bit          m_drop;
  logic [15:0] m_dcnt;

  // monitor state
  int         tr_mode;
  bit         in_pkt, gap_pend, gap_exp, gap2;
  bit         st_pend;
  logic [7:0] st_data;
  logic       st_last;
  int         pkt_bytes;

  task automatic m_reset();
    exp_q.delete();
    m_pix.delete();
    m_occ = 0; m_fid = 8'd0; m_line = 16'd0;
    m_col = 0; m_drop = 1'b0; m_dcnt = 16'd0;
    in_pkt = 0; gap_pend = 0; gap2 = 0;
    st_pend = 0; pkt_bytes = 0;
  endtask

  task automatic m_write(input logic [23:0] a, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
    if (a == 24'd0) begin
      m_fid++;
      m_line = 16'd0;
      m_col  = 0;
    end
    if (m_col == 0) begin
      m_pix.delete();
      m_drop = (m_occ >= 2);
      if (m_drop && m_dcnt != 16'hFFFF) m_dcnt++;
    end
    if (!m_drop) begin
      m_pix.push_back(r);
      m_pix.push_back(g);
      m_pix.push_back(b);
    end
    if (m_col == H - 1) begin
      if (!m_drop) begin
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, m_fid});
        exp_q.push_back({1'b0, m_line[15:8]});
        exp_q.push_back({1'b0, m_line[7:0]});
        for (int i = 0; i < m_pix.size(); i++)
          exp_q.push_back({i == m_pix.size() - 1, m_pix[i]});
        m_occ++;
      end
      m_line++;
      m_col = 0;
    end else begin
      m_col++;
    end
  endtask

  task automatic tick(input bit e, input logic [23:0] a,
                      input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input bit rs);
    logic [8:0] ex;
    @(negedge clk);
    if (gap2) begin
      chk("gap_next_valid", 32'(tvalid), 32'd1);
      gap2 = 0;
    end
    if (gap_pend) begin
      chk("gap_idle", 32'(tvalid), 32'd0);
      gap_pend = 0;
      gap2 = gap_exp;
    end
    if (st_pend) begin
      chk("stall_valid", 32'(tvalid), 32'd1);
      chk("stall_data", 32'(tdata), 32'(st_data));
      chk("stall_last", 32'(tlast), 32'(st_last));
    end
    if (in_pkt) chk("no_bubble", 32'(tvalid), 32'd1);
    rst  = rs;
    ena  = e && !rs;
    addr = a;
    pr_i = r; pg_i = g; pb_i = b;
    if (tr_mode == 1) tready = 1'($urandom_range(0, 1));
    else              tready = (tr_mode == 0);
    if (rs) begin
      m_reset();
    end else begin
      if (e) m_write(a, r, g, b);
      st_pend = tvalid && !tready;
      st_data = tdata;
      st_last = tlast;
      if (tvalid && tready) begin
        if (exp_q.size() > 0) ex = exp_q.pop_front();
        else                  ex = 9'bx;
        chk("byte", 32'({tlast, tdata}), 32'(ex));
        pkt_bytes++;
        in_pkt = (ex[8] !== 1'b1);
        if (ex[8] === 1'b1) begin
          chk("pkt_len", 32'(pkt_bytes), 32'(PLEN));
          pkt_bytes = 0;
          m_occ--;
          gap_pend = 1;
          gap_exp  = (m_occ > 0);
        end
      end
    end
  endtask

  task automatic idle();
    tick(1'b0, 24'hFFFFFF, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  // one scaled line spread over a 1650-clock input line period
  task automatic feed_line(input int ln, input int ncol, input bit rnd);
    for (int c = 0; c < ncol; c++) begin
      logic [7:0] r, g, b;
      if (rnd) begin
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      end else begin
        r = c[7:0]; g = 8'h10; b = 8'h20;
      end
      tick(1'b1, 24'(ln * H + c), r, g, b, 1'b0);
      idle();
      idle();
    end
    repeat (210) idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      idle();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (4) idle();
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
    chk("frame_id", 32'(frame_id), 32'(m_fid));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; addr = '1;
    pr_i = '0; pg_i = '0; pb_i = '0; tready = 1'b1;
    tr_mode = 0;
    m_reset();
    repeat (3) tick(1'b0, '1, 8'd0, 8'd0, 8'd0, 1'b1);
    idle();
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_fid", 32'(frame_id), 32'd0);

    // single line, ramp pattern, no backpressure
    feed_line(0, H, 1'b0);
    drain();

    // three back-to-back lines
    feed_line(1, H, 1'b1);
    feed_line(2, H, 1'b1);
    feed_line(3, H, 1'b1);
    drain();

    // random backpressure on a new frame
    tr_mode = 1;
    feed_line(0, H, 1'b1);
    feed_line(1, H, 1'b1);
    drain();

    // stream blocked for three lines: third is dropped
    tr_mode = 2;
    feed_line(2, H, 1'b1);
    feed_line(3, H, 1'b1);
    feed_line(4, H, 1'b1);
    chk("drop_blocked", 32'(drop_cnt), 32'(m_dcnt));
    tr_mode = 0;
    drain();

    // frame restart mid-line discards partial line
    feed_line(0, 100, 1'b1);
    feed_line(0, H, 1'b1);
    drain();

    // reset mid-packet
    feed_line(0, H, 1'b1);
    chk("in_pix_before_rst", 32'(in_pkt), 32'd1);
    tick(1'b0, '1, 8'd0, 8'd0, 8'd0, 1'b1);
    idle();
    chk("post_rst_tvalid", 32'(tvalid), 32'd0);
    chk("post_rst_fid", 32'(frame_id), 32'd0);
    chk("post_rst_drop", 32'(drop_cnt), 32'd0);
    repeat (20) idle();
    feed_line(0, H, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
